// File: rtl/bus_xfer_ctrl_pkg.sv
// rtl/bus_xfer_ctrl_pkg.sv - shared defaults, FSM encoding and helpers for the register transfer bus
package bus_xfer_ctrl_pkg;

    localparam int unsigned DEF_WIDTH = 8;
    localparam int unsigned DEF_NCH   = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2
    } state_t;

    // Select widths round up to a power of two, so an index can name a missing register.
    function automatic logic src_in_range(input logic [31:0] src, input int unsigned nch);
        return src < nch;
    endfunction

endpackage

// File: rtl/bus_xfer_ctrl_if.sv
// rtl/bus_xfer_ctrl_if.sv - transfer request/response signals between control stage and transfer bus
interface bus_xfer_ctrl_if
    import bus_xfer_ctrl_pkg::*;
#(
    parameter int unsigned NCH = DEF_NCH
);
    localparam int unsigned SELW = $clog2(NCH);

    logic            req_valid;
    logic            req_ready;
    logic [SELW-1:0] req_src;
    logic [NCH-1:0]  req_dst_mask;
    logic            done;
    logic            err_src;
    logic            err_collide;

    modport master (
        output req_valid, req_src, req_dst_mask,
        input  req_ready, done, err_src, err_collide
    );

    modport slave (
        input  req_valid, req_src, req_dst_mask,
        output req_ready, done, err_src, err_collide
    );

endinterface

// File: rtl/bus_xfer_ctrl_bus_reg.sv
// rtl/bus_xfer_ctrl_bus_reg.sv - one bank register: reset beats transfer write beats external load
module bus_reg #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             xfer_we,
    input  logic [WIDTH-1:0] xfer_d,
    input  logic             ld_en,
    input  logic [WIDTH-1:0] ld_d,
    output logic [WIDTH-1:0] q,
    output logic             collide
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (xfer_we) begin
            q <= xfer_d;
        end else if (ld_en) begin
            q <= ld_d;
        end
    end

    // A load that lost to the transfer write on this edge.
    assign collide = xfer_we & ld_en;

endmodule

// File: rtl/bus_xfer_ctrl.sv
// rtl/bus_xfer_ctrl.sv - copies one register through a bus latch into a mask of registers
module bus_xfer_ctrl
    import bus_xfer_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned NCH   = DEF_NCH,
    parameter int unsigned SELW  = $clog2(NCH)
) (
    input  logic                 clk,
    input  logic                 rst,
    bus_xfer_ctrl_if.slave       xf,
    input  logic [NCH-1:0]       ld_en,
    input  logic [NCH*WIDTH-1:0] ld_data,
    output logic [WIDTH-1:0]     bus_out,
    output logic [NCH*WIDTH-1:0] reg_out
);

    state_t             state_q;
    state_t             state_d;
    logic [SELW-1:0]    src_q;
    logic [NCH-1:0]     mask_q;
    logic [WIDTH-1:0]   bus_q;
    logic [WIDTH-1:0]   rd_data;
    logic [WIDTH-1:0]   q_arr [NCH];
    logic [NCH-1:0]     xfer_we;
    logic [NCH-1:0]     collide;
    logic               accept;
    logic               done_q;
    logic               err_src_q;
    logic               err_col_q;

    assign xf.req_ready = (state_q == S_IDLE) && !rst;
    assign accept       = xf.req_valid && xf.req_ready;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = S_READ;
            S_READ:  state_d = S_WRITE;
            S_WRITE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // An out-of-range source matches no register and reads as zero.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < int'(NCH); i++) begin
            if (src_q == SELW'(i)) rd_data = q_arr[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            src_q     <= '0;
            mask_q    <= '0;
            bus_q     <= '0;
            done_q    <= 1'b0;
            err_src_q <= 1'b0;
            err_col_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            done_q    <= (state_q == S_WRITE);
            err_src_q <= accept && !src_in_range(32'(xf.req_src), NCH);
            err_col_q <= |collide;
            if (accept) begin
                src_q  <= xf.req_src;
                mask_q <= xf.req_dst_mask;
            end
            if (state_q == S_READ) bus_q <= rd_data;
        end
    end

    for (genvar g = 0; g < int'(NCH); g++) begin : g_reg
        assign xfer_we[g] = (state_q == S_WRITE) && mask_q[g];

        bus_reg #(.WIDTH(WIDTH)) u_reg (
            .clk     (clk),
            .rst     (rst),
            .xfer_we (xfer_we[g]),
            .xfer_d  (bus_q),
            .ld_en   (ld_en[g]),
            .ld_d    (ld_data[g*WIDTH +: WIDTH]),
            .q       (q_arr[g]),
            .collide (collide[g])
        );

        assign reg_out[g*WIDTH +: WIDTH] = q_arr[g];
    end

    assign bus_out        = bus_q;
    assign xf.done        = done_q;
    assign xf.err_src     = err_src_q;
    assign xf.err_collide = err_col_q;

endmodule

// File: tb/tb_bus_xfer_ctrl.sv
// tb/tb_bus_xfer_ctrl.sv - scoreboard bench for bus_xfer_ctrl with an edge-level reference model
module tb_bus_xfer_ctrl;

    localparam int NCH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  ld_en;
    logic [31:0] ld_data;
    logic [7:0]  bus_out;
    logic [31:0] reg_out;

    logic [2:0]  ld_en3;
    logic [23:0] ld_data3;
    logic [7:0]  bus_out3;
    logic [23:0] reg_out3;

    bus_xfer_ctrl_if #(.NCH(4)) xf ();
    bus_xfer_ctrl_if #(.NCH(3)) xf3 ();

    bus_xfer_ctrl #(.WIDTH(8), .NCH(4)) dut (
        .clk(clk), .rst(rst), .xf(xf), .ld_en(ld_en), .ld_data(ld_data),
        .bus_out(bus_out), .reg_out(reg_out)
    );

    bus_xfer_ctrl #(.WIDTH(8), .NCH(3)) dut3 (
        .clk(clk), .rst(rst), .xf(xf3), .ld_en(ld_en3), .ld_data(ld_data3),
        .bus_out(bus_out3), .reg_out(reg_out3)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int edge_n   = 0;
    int done_seen = 0;
    bit started  = 0;

    // Reference model: registers, bus latch and at most one transfer in flight,
    // tracked by the edge number on which it was accepted.
    logic [7:0] m_reg [NCH];
    logic [7:0] m_bus;
    bit         pend;
    int         acc_e;
    int         p_src;
    logic [3:0] p_mask;
    bit         m_done, m_esrc, m_col;

    typedef struct {
        logic [31:0] regs;
        logic [7:0]  bus;
        int          acc;
    } exp_t;
    exp_t sbq [$];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (edge %0d)", name, got, exp, edge_n);
    endtask

    function automatic logic [31:0] pack_model();
        logic [31:0] r;
        for (int i = 0; i < NCH; i++) r[i*8 +: 8] = m_reg[i];
        return r;
    endfunction

    task automatic model_edge(input int e);
        logic [7:0] old [NCH];
        bit col;
        m_done = 0; m_esrc = 0; m_col = 0;
        if (rst) begin
            for (int i = 0; i < NCH; i++) m_reg[i] = 8'h00;
            m_bus = 8'h00;
            pend  = 0;
            return;
        end
        old = m_reg;
        col = 0;
        for (int i = 0; i < NCH; i++) begin
            if (ld_en[i]) begin
                if (pend && e == acc_e + 2 && p_mask[i]) col = 1;
                else m_reg[i] = ld_data[i*8 +: 8];
            end
        end
        if (pend && e == acc_e + 1) m_bus = (p_src < NCH) ? old[p_src] : 8'h00;
        if (pend && e == acc_e + 2) begin
            for (int i = 0; i < NCH; i++) if (p_mask[i]) m_reg[i] = m_bus;
            m_done = 1;
            m_col  = col;
            pend   = 0;
            sbq.push_back('{regs: pack_model(), bus: m_bus, acc: acc_e});
        end else if (!pend && xf.req_valid) begin
            pend   = 1;
            acc_e  = e;
            p_src  = int'(xf.req_src);
            p_mask = xf.req_dst_mask;
            m_esrc = (p_src >= NCH);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        model_edge(edge_n);
        edge_n++;
    endtask

    task automatic at_neg();
        @(negedge clk);
        #1;
    endtask

    task automatic load(input logic [3:0] en, input logic [31:0] d);
        ld_en = en; ld_data = d;
        tick();
        ld_en = 4'h0;
    endtask

    task automatic xfer(input logic [1:0] s, input logic [3:0] m,
                        input logic [3:0] lb_en, input logic [31:0] lb_d,
                        input logic [3:0] lc_en, input logic [31:0] lc_d);
        xf.req_valid = 1'b1; xf.req_src = s; xf.req_dst_mask = m;
        tick();
        xf.req_valid = 1'b0; ld_en = lb_en; ld_data = lb_d;
        tick();
        ld_en = lc_en; ld_data = lc_d;
        tick();
        ld_en = 4'h0;
        at_neg();
    endtask

    always @(negedge clk) begin
        if (started) begin
            check("req_ready", xf.req_ready, !pend && !rst);
            check("done", xf.done, m_done);
            check("err_src", xf.err_src, m_esrc);
            check("err_collide", xf.err_collide, m_col);
            check("reg_out", reg_out, pack_model());
            check("bus_out", bus_out, m_bus);
            if (xf.done) begin
                done_seen++;
                if (sbq.size() == 0) begin
                    n_checks++;
                    $display("FAIL sb_unexpected_done: got done=1 expected no pending transfer (edge %0d)", edge_n);
                end else begin
                    exp_t ex;
                    ex = sbq.pop_front();
                    check("sb_regs", reg_out, ex.regs);
                    check("sb_bus", bus_out, ex.bus);
                    check("sb_latency", 64'(edge_n - ex.acc), 64'd3);
                end
            end
        end
    end

    initial begin
        int d0;
        rst = 1'b1; ld_en = 4'h0; ld_data = 32'h0;
        xf.req_valid = 1'b0; xf.req_src = 2'd0; xf.req_dst_mask = 4'h0;
        ld_en3 = 3'h0; ld_data3 = 24'h0;
        xf3.req_valid = 1'b0; xf3.req_src = 2'd0; xf3.req_dst_mask = 3'h0;

        // Reset
        tick();
        started = 1;
        tick();
        at_neg();
        check("rst_reg_out", reg_out, 32'h0);
        check("rst_bus_out", bus_out, 8'h0);
        check("rst_ready", xf.req_ready, 1'b0);
        check("rst_done", xf.done, 1'b0);
        rst = 1'b0;
        #1;
        check("ready_after_rst", xf.req_ready, 1'b1);

        // Load then copy
        load(4'b0011, 32'h0000_02A1);
        xfer(2'd0, 4'b0010, 4'h0, 32'h0, 4'h0, 32'h0);
        check("copy_done", xf.done, 1'b1);
        check("copy_regs", reg_out, 32'h0000_A1A1);
        check("copy_bus", bus_out, 8'hA1);

        // Broadcast with ready-low window
        load(4'b0100, 32'h005C_0000);
        xf.req_valid = 1'b1; xf.req_src = 2'd2; xf.req_dst_mask = 4'b1011;
        tick();
        xf.req_valid = 1'b0;
        at_neg(); check("bcast_ready_c1", xf.req_ready, 1'b0);
        tick();
        at_neg(); check("bcast_ready_c2", xf.req_ready, 1'b0);
        tick();
        at_neg(); check("bcast_ready_c3", xf.req_ready, 1'b1);
        check("bcast_done", xf.done, 1'b1);
        check("bcast_regs", reg_out, 32'h5C5C_5C5C);

        // Collision on the write edge; unmasked load on the same edge lands
        load(4'b0001, 32'h0000_0033);
        xfer(2'd0, 4'b0010, 4'h0, 32'h0, 4'b1010, 32'h7700_FF00);
        check("collide_flag", xf.err_collide, 1'b1);
        check("collide_regs", reg_out, 32'h775C_3333);

        // Load to the source on the read edge: bus sees old, reg keeps new
        xfer(2'd2, 4'b0001, 4'b0100, 32'h00EE_0000, 4'h0, 32'h0);
        check("srcload_regs", reg_out, 32'h77EE_335C);
        check("srcload_bus", bus_out, 8'h5C);

        // Reset during READ aborts the transfer
        load(4'b1111, 32'h4433_2211);
        xf.req_valid = 1'b1; xf.req_src = 2'd1; xf.req_dst_mask = 4'b1111;
        tick();
        xf.req_valid = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        tick();
        at_neg();
        check("abort_regs", reg_out, 32'h0);
        check("abort_ready", xf.req_ready, 1'b1);
        load(4'b0010, 32'h0000_9900);
        xfer(2'd1, 4'b0101, 4'h0, 32'h0, 4'h0, 32'h0);
        check("after_abort_done", xf.done, 1'b1);
        check("after_abort_regs", reg_out, 32'h0099_9999);

        // Empty mask and self-copy
        xfer(2'd1, 4'b0000, 4'h0, 32'h0, 4'h0, 32'h0);
        check("mask0_done", xf.done, 1'b1);
        check("mask0_regs", reg_out, 32'h0099_9999);
        xfer(2'd2, 4'b0100, 4'h0, 32'h0, 4'h0, 32'h0);
        check("self_regs", reg_out, 32'h0099_9999);

        // Back-to-back requests with valid held high
        d0 = done_seen;
        xf.req_valid = 1'b1; xf.req_src = 2'd3; xf.req_dst_mask = 4'b0001;
        repeat (9) tick();
        xf.req_valid = 1'b0;
        at_neg();
        check("b2b_done_count", 64'(done_seen - d0), 64'd3);

        // Randomized traffic
        repeat (400) begin
            rst          = ($urandom_range(0, 63) == 0);
            ld_en        = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
            ld_data      = $urandom;
            xf.req_valid = 1'($urandom_range(0, 1));
            xf.req_src   = 2'($urandom);
            xf.req_dst_mask = 4'($urandom);
            tick();
        end
        rst = 1'b0; ld_en = 4'h0; xf.req_valid = 1'b0;
        repeat (4) tick();

        // Three-register build: out-of-range source
        ld_en3 = 3'b111; ld_data3 = 24'h33_2211;
        tick();
        ld_en3 = 3'b000;
        xf3.req_valid = 1'b1; xf3.req_src = 2'd3; xf3.req_dst_mask = 3'b101;
        tick();
        xf3.req_valid = 1'b0;
        at_neg();
        check("n3_err_src", xf3.err_src, 1'b1);
        check("n3_ready_busy", xf3.req_ready, 1'b0);
        tick();
        at_neg();
        check("n3_err_src_clear", xf3.err_src, 1'b0);
        check("n3_bus", bus_out3, 8'h00);
        tick();
        at_neg();
        check("n3_done", xf3.done, 1'b1);
        check("n3_regs", reg_out3, 24'h00_2200);

        check("sb_empty", 64'(sbq.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
